rs: RTL and testbench
=====================

Name: rs

Overview:
- Single-issue reservation station for one functional-unit class in the out-of-order core.
- Sits between dispatch (upstream) and the FU (downstream).
- Buffers renamed instructions and tracks physical-source readiness through three wakeup ports.
- Issues the oldest entry whose operands are both ready when the FU is ready.
- Announces each newly allocated destination physical register so it can be marked not-ready.

Parameters:
- DEPTH, 8, number of RS entries.
- AGE_W, 4, width of the per-entry saturating age counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- fu_rdy  in  1  FU can accept an instruction this cycle
- valid_in  in  1  dispatch valid
- ready_in  out  1  RS has at least one free entry
- instr  in  dispatch_pipeline_data  fields: Opcode[6:0], prd[6:0], pr1[6:0], pr1_ready, pr2[6:0], pr2_ready, imm[31:0], rob_index[3:0]
- valid_out  out  1  issue valid; one-cycle pulse
- data_out  out  rs_data[1:0]  [1] = issued entry; [0] driven all-zero
- nr_reg  out  7  dest preg of the last accepted dispatch
- nr_valid  out  1  nr_reg valid; one-cycle pulse
- reg1_rdy, reg2_rdy, reg3_rdy  in  7 each  pregs becoming ready
- reg1_rdy_valid, reg2_rdy_valid, reg3_rdy_valid  in  1 each  qualifiers for the three wakeup pregs
- flush  in  1  discard all entries

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high.
- Reset clears all entry valid bits, valid_out, nr_valid, nr_reg and data_out to 0. Reset mid-operation drops all contents.
- ready_in is combinational: 1 iff any entry is free. Not gated by flush or valid_in.
- Accept: valid_in && ready_in && !flush at a rising edge.
  - Write to the lowest-index free entry with age=0.
  - fu is decoded from Opcode: 0x63/0x6F/0x67 -> 2'b01; 0x03/0x23 -> 2'b10; all others -> 2'b00.
  - Same-edge dispatch wakeup: entry pr1_ready = instr.pr1_ready OR (pr1 matches any regN_rdy with its valid set). pr2 likewise.
- nr_valid/nr_reg: registered. On an accepted edge, nr_valid<=1 and nr_reg<=instr.prd. On any other edge, nr_valid<=0 and nr_reg holds.
- Wakeup: each edge, every valid entry sets prX_ready for any regN_rdy_valid port whose regN_rdy equals prX. All 3 ports × 2 sources are compared in parallel.
- Issue eligibility: entry valid AND (pr1_ready or pr1 woken this cycle) AND (pr2_ready or pr2 woken this cycle). Wakeup bypasses into select in the same cycle.
- Select: if fu_rdy and any entry is eligible, pick the largest age; ties go to the lowest index.
  - At the edge: data_out[1] <= selected entry, with ready bits reflecting the wakeups; valid_out <= 1; free the entry.
  - Otherwise valid_out <= 0 and data_out holds.
- An entry written this edge is not issue-eligible until the next edge. Dispatch and issue may both occur on one edge, including into the entry being freed only on later edges.
- Age: each edge, every valid entry not issued increments age, saturating at 2^AGE_W-1.
- Flush has priority over dispatch, wakeup and issue. At the edge: clear all entries, valid_out<=0, nr_valid<=0. Nothing flushed ever issues.
- Full: ready_in=0 and valid_in is ignored. Empty: valid_out stays 0.

Decomposition:
- types_pkg holds dispatch_pipeline_data, rs_data (valid, Opcode, prd, pr1, pr1_ready, pr2, pr2_ready, imm, rob_index, fu[1:0], age[AGE_W-1:0]), and the FU-class constants.
- Optional sub-module rs_select: oldest-ready picker over DEPTH entries returning found+index.

Test Plan:
1. Reset 3 cycles, then dispatch prd=10 pr1=1(0) pr2=2(0) rob=1 op=0x33 with fu_rdy=1 -> valid_out stays 0 for 3+ cycles; ready_in=1.
2. Wake preg 1 only -> still no issue. Then wake preg 2 -> valid_out pulses once with data_out[1] prd=10 pr1=1 rdy1=1 pr2=2 rdy2=1 fu=00 rob=1.
3. Dispatch prd=20 -> on the following edge nr_valid=1 and nr_reg=20; next cycle nr_valid=0.
4. Dispatch prd=21 (srcs 7,8) and prd=22 (srcs 9,10), assert flush 1 cycle, then wake 7,8,9 -> no valid_out for 4+ cycles.
5. Dispatch A (prd 30, srcs 30/31, rob 5), then B (prd 40, srcs 40/41, rob 6). Wake 40,41 -> B issues first. Wake 30,31 -> A issues.
6. Fill 8 entries with unready sources -> ready_in=0 and a 9th valid_in is dropped. Wake all sources -> issue in dispatch order, one per cycle; ready_in returns to 1 after the first issue.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the reservation station: dispatch payload, stored entry, FU classes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rs_pkg;

    localparam int RS_DEPTH = 8;
    localparam int AGE_W    = 4;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // Functional-unit class carried with each entry
    localparam logic [1:0] FU_ALU    = 2'b00;
    localparam logic [1:0] FU_BRANCH = 2'b01;
    localparam logic [1:0] FU_MEM    = 2'b10;

    typedef struct packed {
        logic [6:0]  Opcode;
        logic [6:0]  prd;
        logic [6:0]  pr1;
        logic        pr1_ready;
        logic [6:0]  pr2;
        logic        pr2_ready;
        logic [31:0] imm;
        logic [3:0]  rob_index;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic             valid;
        logic [6:0]       Opcode;
        logic [6:0]       prd;
        logic [6:0]       pr1;
        logic             pr1_ready;
        logic [6:0]       pr2;
        logic             pr2_ready;
        logic [31:0]      imm;
        logic [3:0]       rob_index;
        logic [1:0]       fu;
        logic [AGE_W-1:0] age;
    } rs_data;

    function automatic logic [1:0] fu_decode(input logic [6:0] op);
        case (op)
            7'h63, 7'h6F, 7'h67: return FU_BRANCH;
            7'h03, 7'h23:        return FU_MEM;
            default:             return FU_ALU;
        endcase
    endfunction

    // True when any of the three wakeup ports announces preg p this cycle
    function automatic logic preg_woken(
        input logic [6:0] p,
        input logic [6:0] r1, input logic v1,
        input logic [6:0] r2, input logic v2,
        input logic [6:0] r3, input logic v3
    );
        return (v1 && (r1 == p)) || (v2 && (r2 == p)) || (v3 && (r3 == p));
    endfunction

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: largest age among eligible entries, lowest index on ties.
// Latency: combinational.
// Backpressure: none; caller qualifies the result with FU readiness.
// Ports: elig (per-entry eligible), ages (per-entry age), found, idx (winner).
module rs_select
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int IDX_W = 3
) (
    input  logic [DEPTH-1:0]            elig,
    input  logic [DEPTH-1:0][AGE_W-1:0] ages,
    output logic                        found,
    output logic [IDX_W-1:0]            idx
);

    logic [AGE_W-1:0] best;

    // Ascending scan with strict '>' keeps the lowest index among equal ages
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && (!found || (ages[i] > best))) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                best  = ages[i];
            end
        end
    end

endmodule

// File: rtl/rs.sv
// Single-issue reservation station: buffers renamed instrs, tracks source wakeups, issues oldest ready.
// Latency: dispatch-to-issue >= 1 edge; issue and nr announcements are registered one-cycle pulses.
// Backpressure: ready_in drops only when every entry is occupied; issue waits on fu_rdy.
// Ports: clk/reset (sync, active-high), dispatch valid_in/ready_in/instr, issue valid_out/data_out,
//        nr_reg/nr_valid dest announce, reg{1,2,3}_rdy(_valid) wakeups, flush.
module rs
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fu_rdy,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  dispatch_pipeline_data instr,
    output logic                  valid_out,
    output rs_data [1:0]          data_out,
    output logic [6:0]            nr_reg,
    output logic                  nr_valid,
    input  logic [6:0]            reg1_rdy,
    input  logic [6:0]            reg2_rdy,
    input  logic [6:0]            reg3_rdy,
    input  logic                  reg1_rdy_valid,
    input  logic                  reg2_rdy_valid,
    input  logic                  reg3_rdy_valid,
    input  logic                  flush
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_data ent [DEPTH];

    logic [DEPTH-1:0]            w1, w2, elig;
    logic [DEPTH-1:0][AGE_W-1:0] ages;
    logic                        free_found, sel_found;
    logic [IDX_W-1:0]            free_idx, sel_idx;
    logic                        accept, issue;
    rs_data                      new_ent, issued;

    // Per-entry wakeup match and eligibility; wakeups bypass straight into select
    always_comb begin
        w1   = '0;
        w2   = '0;
        elig = '0;
        ages = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = preg_woken(ent[i].pr1, reg1_rdy, reg1_rdy_valid,
                               reg2_rdy, reg2_rdy_valid, reg3_rdy, reg3_rdy_valid);
            w2[i] = preg_woken(ent[i].pr2, reg1_rdy, reg1_rdy_valid,
                               reg2_rdy, reg2_rdy_valid, reg3_rdy, reg3_rdy_valid);
            elig[i] = ent[i].valid && (ent[i].pr1_ready || w1[i]) && (ent[i].pr2_ready || w2[i]);
            ages[i] = ent[i].age;
        end
    end

    // Lowest-index free slot
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
        .elig  (elig),
        .ages  (ages),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign ready_in = free_found;
    assign accept   = valid_in && free_found;   // flush overrides in the sequential block
    assign issue    = fu_rdy && sel_found;

    // New entry picks up wakeups arriving on its own dispatch edge
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.Opcode    = instr.Opcode;
        new_ent.prd       = instr.prd;
        new_ent.pr1       = instr.pr1;
        new_ent.pr1_ready = instr.pr1_ready ||
                            preg_woken(instr.pr1, reg1_rdy, reg1_rdy_valid,
                                       reg2_rdy, reg2_rdy_valid, reg3_rdy, reg3_rdy_valid);
        new_ent.pr2       = instr.pr2;
        new_ent.pr2_ready = instr.pr2_ready ||
                            preg_woken(instr.pr2, reg1_rdy, reg1_rdy_valid,
                                       reg2_rdy, reg2_rdy_valid, reg3_rdy, reg3_rdy_valid);
        new_ent.imm       = instr.imm;
        new_ent.rob_index = instr.rob_index;
        new_ent.fu        = fu_decode(instr.Opcode);
        new_ent.age       = '0;
    end

    // Issued copy shows the ready bits as they stand after this cycle's wakeups
    always_comb begin
        issued           = ent[sel_idx];
        issued.pr1_ready = ent[sel_idx].pr1_ready | w1[sel_idx];
        issued.pr2_ready = ent[sel_idx].pr2_ready | w2[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            valid_out <= 1'b0;
            nr_valid  <= 1'b0;
            nr_reg    <= '0;
            data_out  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
            valid_out <= 1'b0;
            nr_valid  <= 1'b0;
        end else begin
            valid_out <= issue;
            nr_valid  <= accept;
            if (accept) begin
                nr_reg <= instr.prd;
            end
            if (issue) begin
                data_out[1] <= issued;
                data_out[0] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent[i].valid) begin
                    ent[i].pr1_ready <= ent[i].pr1_ready | w1[i];
                    ent[i].pr2_ready <= ent[i].pr2_ready | w2[i];
                    if (issue && (sel_idx == IDX_W'(i))) begin
                        ent[i].valid <= 1'b0;
                    end else if (ent[i].age != AGE_MAX) begin
                        ent[i].age <= ent[i].age + AGE_W'(1);
                    end
                end
            end
            // Target slot is currently free, so it never collides with the loop above
            if (accept) begin
                ent[free_idx] <= new_ent;
            end
        end
    end

endmodule

// File: tb/tb_rs.sv
module tb_rs;
    import rs_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  fu_rdy = 1'b0;
    logic                  valid_in = 1'b0;
    logic                  ready_in;
    dispatch_pipeline_data instr = '0;
    logic                  valid_out;
    rs_data [1:0]          data_out;
    logic [6:0]            nr_reg;
    logic                  nr_valid;
    logic [6:0]            reg1_rdy = '0, reg2_rdy = '0, reg3_rdy = '0;
    logic                  reg1_rdy_valid = 1'b0, reg2_rdy_valid = 1'b0, reg3_rdy_valid = 1'b0;
    logic                  flush = 1'b0;

    rs dut (
        .clk(clk), .reset(reset), .fu_rdy(fu_rdy), .valid_in(valid_in), .ready_in(ready_in),
        .instr(instr), .valid_out(valid_out), .data_out(data_out), .nr_reg(nr_reg),
        .nr_valid(nr_valid), .reg1_rdy(reg1_rdy), .reg2_rdy(reg2_rdy), .reg3_rdy(reg3_rdy),
        .reg1_rdy_valid(reg1_rdy_valid), .reg2_rdy_valid(reg2_rdy_valid),
        .reg3_rdy_valid(reg3_rdy_valid), .flush(flush)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    logic mon_en = 1'b0;
    logic exp_rdy = 1'b1;

    typedef struct { int tag; rs_data d; } iss_t;
    typedef struct { int tag; logic [6:0] r; } nr_t;
    iss_t iss_q[$];
    nr_t  nr_q[$];

    // Reference model: slot occupancy, stored payload and the edge each entry arrived on
    logic                  m_vld [8];
    dispatch_pipeline_data m_d [8];
    int                    m_stamp [8];

    // Stimulus for the next edge
    logic                  n_vin = 1'b0, n_fr = 1'b1, n_fl = 1'b0, n_rst = 1'b1;
    dispatch_pipeline_data n_d = '0;
    logic [2:0][6:0]       n_wr = '0;
    logic [2:0]            n_wv = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic woke(input logic [6:0] p);
        return (n_wv[0] && n_wr[0] == p) || (n_wv[1] && n_wr[1] == p) || (n_wv[2] && n_wr[2] == p);
    endfunction

    function automatic logic [1:0] ref_fu(input logic [6:0] op);
        if (op == 7'h63 || op == 7'h6F || op == 7'h67) return 2'b01;
        if (op == 7'h03 || op == 7'h23) return 2'b10;
        return 2'b00;
    endfunction

    function automatic dispatch_pipeline_data mk(input int prd, input int p1, input int p2,
                                                 input int rob, input logic [6:0] op);
        dispatch_pipeline_data d;
        d.Opcode = op;           d.prd = 7'(prd);
        d.pr1 = 7'(p1);          d.pr1_ready = 1'b0;
        d.pr2 = 7'(p2);          d.pr2_ready = 1'b0;
        d.imm = $urandom;        d.rob_index = 4'(rob);
        return d;
    endfunction

    task automatic wk(input int a, input int b, input int c);
        n_wr[0] = 7'(a); n_wv[0] = (a >= 0);
        n_wr[1] = 7'(b); n_wv[1] = (b >= 0);
        n_wr[2] = 7'(c); n_wv[2] = (c >= 0);
    endtask

    // Drive one edge's inputs and advance the model across that edge
    task automatic step();
        int e, fs, pick, best, a;
        rs_data x;
        @(negedge clk);
        reset = n_rst; valid_in = n_vin; instr = n_d; fu_rdy = n_fr; flush = n_fl;
        reg1_rdy = n_wr[0]; reg2_rdy = n_wr[1]; reg3_rdy = n_wr[2];
        reg1_rdy_valid = n_wv[0]; reg2_rdy_valid = n_wv[1]; reg3_rdy_valid = n_wv[2];
        e = edge_cnt + 1;
        if (n_rst || n_fl) begin
            for (int s = 0; s < 8; s++) m_vld[s] = 1'b0;
        end else begin
            fs = -1;
            for (int s = 7; s >= 0; s--) if (!m_vld[s]) fs = s;
            pick = -1; best = -1;
            if (n_fr) begin
                for (int s = 0; s < 8; s++) begin
                    if (m_vld[s] && (m_d[s].pr1_ready || woke(m_d[s].pr1))
                                 && (m_d[s].pr2_ready || woke(m_d[s].pr2))) begin
                        a = e - m_stamp[s] - 1;   // edges spent waiting, saturating at 15
                        if (a > 15) a = 15;
                        if (a > best) begin pick = s; best = a; end
                    end
                end
            end
            if (pick >= 0) begin
                x.valid = 1'b1;            x.Opcode = m_d[pick].Opcode;
                x.prd = m_d[pick].prd;     x.pr1 = m_d[pick].pr1;
                x.pr1_ready = 1'b1;        x.pr2 = m_d[pick].pr2;
                x.pr2_ready = 1'b1;        x.imm = m_d[pick].imm;
                x.rob_index = m_d[pick].rob_index;
                x.fu = ref_fu(m_d[pick].Opcode);
                x.age = 4'(best);
                iss_q.push_back('{tag: e, d: x});
                m_vld[pick] = 1'b0;
            end
            for (int s = 0; s < 8; s++) begin
                if (m_vld[s]) begin
                    if (woke(m_d[s].pr1)) m_d[s].pr1_ready = 1'b1;
                    if (woke(m_d[s].pr2)) m_d[s].pr2_ready = 1'b1;
                end
            end
            if (n_vin && fs >= 0) begin
                m_vld[fs] = 1'b1;
                m_d[fs] = n_d;
                m_d[fs].pr1_ready = n_d.pr1_ready || woke(n_d.pr1);
                m_d[fs].pr2_ready = n_d.pr2_ready || woke(n_d.pr2);
                m_stamp[fs] = e;
                nr_q.push_back('{tag: e, r: n_d.prd});
            end
        end
        exp_rdy = 1'b0;
        for (int s = 0; s < 8; s++) if (!m_vld[s]) exp_rdy = 1'b1;
        mon_en = 1'b1;
        n_vin = 1'b0; n_fl = 1'b0; n_rst = 1'b0; n_wv = '0;
    endtask

    // Monitor: pops expectations whenever the DUT presents an issue or nr pulse
    initial begin
        iss_t ie;
        nr_t  ne;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (mon_en) begin
                chk("ready_in", ready_in, exp_rdy);
                if (valid_out) begin
                    if (iss_q.size() == 0) chk("unexpected_issue", valid_out, 1'b0);
                    else begin
                        ie = iss_q.pop_front();
                        chk("issue_edge", edge_cnt, ie.tag);
                        chk("issue_data", data_out[1], ie.d);
                        chk("data_out0", data_out[0], 0);
                    end
                end else if (iss_q.size() != 0 && iss_q[0].tag <= edge_cnt) begin
                    ie = iss_q.pop_front();
                    chk("missing_issue", valid_out, 1'b1);
                end
                if (nr_valid) begin
                    if (nr_q.size() == 0) chk("unexpected_nr", nr_valid, 1'b0);
                    else begin
                        ne = nr_q.pop_front();
                        chk("nr_edge", edge_cnt, ne.tag);
                        chk("nr_reg", nr_reg, ne.r);
                    end
                end else if (nr_q.size() != 0 && nr_q[0].tag <= edge_cnt) begin
                    ne = nr_q.pop_front();
                    chk("missing_nr", nr_valid, 1'b1);
                end
            end
        end
    end

    initial begin
        logic [6:0] ops [7];
        ops = '{7'h33, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h13};
        for (int s = 0; s < 8; s++) begin m_vld[s] = 1'b0; m_stamp[s] = 0; m_d[s] = '0; end

        // Reset
        n_rst = 1'b1; step(); n_rst = 1'b1; step(); n_rst = 1'b1; step();
        @(posedge clk); #2;
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_nr_valid", nr_valid, 1'b0);
        chk("rst_nr_reg", nr_reg, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ready_in", ready_in, 1'b1);

        // 1: unready sources never issue
        n_vin = 1'b1; n_d = mk(10, 1, 2, 1, 7'h33); step();
        repeat (4) step();
        @(posedge clk); #2;
        chk("t1_no_issue", valid_out, 1'b0);
        chk("t1_ready_in", ready_in, 1'b1);

        // 2: wake one source, then the other
        wk(1, -1, -1); step(); repeat (2) step();
        chk("t2_half_woken", valid_out, 1'b0);
        wk(-1, 2, -1); step();
        @(posedge clk); #2;
        chk("t2_issue", valid_out, 1'b1);
        chk("t2_prd", data_out[1].prd, 10);
        chk("t2_fields", {data_out[1].pr1, data_out[1].pr1_ready, data_out[1].pr2,
                          data_out[1].pr2_ready, data_out[1].fu, data_out[1].rob_index},
                         {7'd1, 1'b1, 7'd2, 1'b1, 2'b00, 4'd1});
        step();
        @(posedge clk); #2;
        chk("t2_pulse", valid_out, 1'b0);

        // 3: destination announce
        n_vin = 1'b1; n_d = mk(20, 50, 51, 2, 7'h13); step();
        @(posedge clk); #2;
        chk("t3_nr_valid", nr_valid, 1'b1);
        chk("t3_nr_reg", nr_reg, 20);
        step();
        @(posedge clk); #2;
        chk("t3_nr_pulse", nr_valid, 1'b0);

        // 4: flush discards entries (and a same-edge dispatch)
        n_vin = 1'b1; n_d = mk(21, 7, 8, 3, 7'h03); step();
        n_vin = 1'b1; n_d = mk(22, 9, 10, 4, 7'h63); step();
        n_fl = 1'b1; n_vin = 1'b1; n_d = mk(23, 11, 12, 5, 7'h33); step();
        wk(7, 8, 9); step();
        repeat (4) step();
        @(posedge clk); #2;
        chk("t4_no_issue", valid_out, 1'b0);

        // 5: younger ready entry issues before older unready one
        n_vin = 1'b1; n_d = mk(30, 30, 31, 5, 7'h23); step();
        n_vin = 1'b1; n_d = mk(40, 40, 41, 6, 7'h67); step();
        wk(40, 41, -1); step();
        @(posedge clk); #2;
        chk("t5_b_first", {valid_out, data_out[1].prd, data_out[1].rob_index}, {1'b1, 7'd40, 4'd6});
        wk(30, 31, -1); step();
        @(posedge clk); #2;
        chk("t5_a_next", {valid_out, data_out[1].prd, data_out[1].rob_index}, {1'b1, 7'd30, 4'd5});

        // 6: fill, drop 9th, then drain in dispatch order
        for (int i = 0; i < 8; i++) begin
            n_vin = 1'b1; n_d = mk(100 + i, 60 + 2 * i, 61 + 2 * i, i, ops[i % 7]); step();
        end
        @(posedge clk); #2;
        chk("t6_full", ready_in, 1'b0);
        n_vin = 1'b1; n_d = mk(120, 1, 2, 9, 7'h33); step();
        @(posedge clk); #2;
        chk("t6_drop_nr", nr_valid, 1'b0);
        n_fr = 1'b0;
        for (int i = 0; i < 6; i++) begin wk(60 + 3 * i, 61 + 3 * i, 62 + 3 * i); step(); end
        n_fr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            @(posedge clk); #2;
            chk("t6_order", {valid_out, data_out[1].prd}, {1'b1, 7'(100 + i)});
            if (i == 0) chk("t6_ready_back", ready_in, 1'b1);
        end

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            n_vin = ($urandom_range(0, 9) < 6);
            n_d = mk($urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), ops[$urandom_range(0, 6)]);
            n_d.pr1_ready = ($urandom_range(0, 3) == 0);
            n_d.pr2_ready = ($urandom_range(0, 3) == 0);
            n_fr = ($urandom_range(0, 9) < 6);
            n_fl = ($urandom_range(0, 99) < 2);
            n_rst = (c == 1200);
            for (int k = 0; k < 3; k++) begin
                n_wv[k] = ($urandom_range(0, 3) == 0);
                n_wr[k] = 7'($urandom_range(0, 15));
            end
            step();
        end
        n_fr = 1'b1;
        repeat (3) step();
        @(posedge clk); #3;
        chk("iss_q_drained", iss_q.size(), 0);
        chk("nr_q_drained", nr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
